// File: rtl/dma_ctrl.sv
// DMA engine on the CPU side of the serial link: stores received bytes into a RAM
// window (followed by a flag byte) and streams a RAM window out to the transmitter.
module dma_ctrl #(
  parameter logic [7:0] RX_BASE   = 8'h00,
  parameter int         RX_LEN    = 3,
  parameter logic [7:0] FLAG_ADDR = 8'h03,
  parameter logic [7:0] FLAG_VAL  = 8'hFF,
  parameter logic [7:0] TX_BASE   = 8'h04,
  parameter int         TX_LEN    = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] RX_Data,
  input  logic       RX_Valid,
  output logic       Data_Read,
  output logic [7:0] TX_Data,
  output logic       Valid_D,
  input  logic       TX_Rdy,
  output logic       DMA_Req,
  input  logic       DMA_Ack,
  input  logic       DMA_Tx_Start,
  output logic       DMA_Ready,
  output logic [7:0] RAM_Addr,
  output logic       RAM_Cs,
  output logic       RAM_Wen,
  output logic       RAM_Oen,
  output logic [7:0] DataOut,
  input  logic [7:0] DataIn
);

  localparam int RXW = $clog2(RX_LEN + 1);
  localparam int TXW = $clog2(TX_LEN + 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(RX_LEN - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_LEN - 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] RX_REQ   = 4'd1;
  localparam logic [3:0] RX_WRITE = 4'd2;
  localparam logic [3:0] RX_FLAG  = 4'd3;
  localparam logic [3:0] TX_READ  = 4'd4;
  localparam logic [3:0] TX_LATCH = 4'd5;
  localparam logic [3:0] TX_SEND  = 4'd6;
  localparam logic [3:0] TX_BUSY  = 4'd7;
  localparam logic [3:0] TX_DONE  = 4'd8;

  logic [3:0]     state_q, state_d;
  logic [RXW-1:0] rx_idx_q, rx_idx_d;
  logic [TXW-1:0] tx_idx_q, tx_idx_d;
  logic           tx_pend_q, tx_pend_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      rx_idx_q  <= '0;
      tx_idx_q  <= '0;
      tx_pend_q <= 1'b0;
      tx_data_q <= 8'h00;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_idx_q  <= rx_idx_d;
      tx_idx_q  <= tx_idx_d;
      tx_pend_q <= tx_pend_d;
      tx_data_q <= tx_data_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rx_idx_d  = rx_idx_q;
    tx_idx_d  = tx_idx_q;
    tx_pend_d = tx_pend_q;
    tx_data_d = tx_data_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;

    // Start requests arriving mid-job collapse into a single pending job.
    if (state_q != IDLE && DMA_Tx_Start) begin
      tx_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (DMA_Tx_Start || tx_pend_q) begin
          state_d   = TX_READ;
          ready_d   = 1'b0;
          tx_pend_d = 1'b0;
        end else if (RX_Valid) begin
          state_d = RX_REQ;
        end
      end
      RX_REQ: begin
        if (DMA_Ack) begin
          state_d = RX_WRITE;
        end
      end
      RX_WRITE: begin
        if (rx_idx_q == RX_LAST) begin
          state_d = RX_FLAG;
        end else begin
          rx_idx_d = rx_idx_q + 1'b1;
          state_d  = IDLE;
        end
      end
      RX_FLAG: begin
        rx_idx_d = '0;
        state_d  = IDLE;
      end
      TX_READ: begin
        state_d = TX_LATCH;
      end
      TX_LATCH: begin
        tx_data_d = DataIn;
        state_d   = TX_SEND;
      end
      TX_SEND: begin
        // Valid_D is registered so it shows in the first TX_BUSY cycle only.
        if (TX_Rdy) begin
          valid_d = 1'b1;
          state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (!TX_Rdy) begin
          if (tx_idx_q == TX_LAST) begin
            tx_idx_d = '0;
            state_d  = TX_DONE;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
            state_d  = TX_READ;
          end
        end
      end
      TX_DONE: begin
        if (TX_Rdy) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    Data_Read = 1'b0;
    DMA_Req   = 1'b0;
    RAM_Addr  = 8'h00;
    RAM_Cs    = 1'b0;
    RAM_Wen   = 1'b0;
    RAM_Oen   = 1'b0;
    DataOut   = 8'h00;
    case (state_q)
      RX_REQ: begin
        DMA_Req = 1'b1;
      end
      RX_WRITE: begin
        DMA_Req   = 1'b1;
        RAM_Cs    = 1'b1;
        RAM_Wen   = 1'b1;
        RAM_Addr  = RX_BASE + 8'(rx_idx_q);
        DataOut   = RX_Data;
        Data_Read = 1'b1;
      end
      RX_FLAG: begin
        DMA_Req  = 1'b1;
        RAM_Cs   = 1'b1;
        RAM_Wen  = 1'b1;
        RAM_Addr = FLAG_ADDR;
        DataOut  = FLAG_VAL;
      end
      TX_READ, TX_LATCH: begin
        RAM_Cs   = 1'b1;
        RAM_Oen  = 1'b1;
        RAM_Addr = TX_BASE + 8'(tx_idx_q);
      end
      default: begin
      end
    endcase
  end

  assign TX_Data   = tx_data_q;
  assign Valid_D   = valid_q;
  assign DMA_Ready = ready_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with small RAM, receiver FIFO, transmitter and CPU grant models.
module tb_dma_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] RX_Data;
  logic       RX_Valid;
  logic       Data_Read;
  logic [7:0] TX_Data;
  logic       Valid_D;
  logic       TX_Rdy;
  logic       DMA_Req;
  logic       DMA_Ack = 1'b0;
  logic       DMA_Tx_Start;
  logic       DMA_Ready;
  logic [7:0] RAM_Addr;
  logic       RAM_Cs;
  logic       RAM_Wen;
  logic       RAM_Oen;
  logic [7:0] DataOut;
  logic [7:0] DataIn = 8'h00;

  always #5 Clk = ~Clk;

  dma_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .RX_Data(RX_Data), .RX_Valid(RX_Valid), .Data_Read(Data_Read),
    .TX_Data(TX_Data), .Valid_D(Valid_D), .TX_Rdy(TX_Rdy),
    .DMA_Req(DMA_Req), .DMA_Ack(DMA_Ack), .DMA_Tx_Start(DMA_Tx_Start), .DMA_Ready(DMA_Ready),
    .RAM_Addr(RAM_Addr), .RAM_Cs(RAM_Cs), .RAM_Wen(RAM_Wen), .RAM_Oen(RAM_Oen),
    .DataOut(DataOut), .DataIn(DataIn)
  );

  // Receiver FIFO: bench pushes, DUT pops.
  logic [7:0] rx_mem [16];
  logic [3:0] rx_wp = 4'd0;
  logic [3:0] rx_rp = 4'd0;
  assign RX_Valid = (rx_wp != rx_rp);
  assign RX_Data  = rx_mem[rx_rp];
  always @(posedge Clk) if (Data_Read) rx_rp <= rx_rp + 4'd1;

  // RAM: registered read; writes are logged as {addr,data}.
  logic [7:0]  mem [256];
  logic [15:0] wr_log [$];
  logic [7:0]  rd_log [$];
  always @(posedge Clk) begin
    if (RAM_Cs && RAM_Wen) wr_log.push_back({RAM_Addr, DataOut});
    if (RAM_Cs && RAM_Oen) begin
      DataIn <= mem[RAM_Addr];
      rd_log.push_back(RAM_Addr);
    end
  end

  // Transmitter: busy for 20 cycles after each start strobe.
  logic       tx_idle  = 1'b1;
  logic       tx_block = 1'b0;
  int         busy     = 0;
  logic [7:0] tx_log [$];
  assign TX_Rdy = tx_idle & ~tx_block;
  always @(posedge Clk) begin
    if (Valid_D) begin
      tx_log.push_back(TX_Data);
      tx_idle <= 1'b0;
      busy    <= 20;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) tx_idle <= 1'b1;
    end
  end

  // CPU grant: Ack follows Req after ack_delay cycles, held while Req=1.
  int ack_delay = 2;
  int ack_cnt   = 0;
  always @(posedge Clk) begin
    if (!DMA_Req) begin
      DMA_Ack <= 1'b0;
      ack_cnt <= 0;
    end else if (ack_cnt >= ack_delay) begin
      DMA_Ack <= 1'b1;
    end else begin
      ack_cnt <= ack_cnt + 1;
    end
  end

  // Event monitor sampled at the clock edge.
  int   cyc = 0, last_rdy_rise = 0, last_ready_rise = 0, last_req_rise = 0;
  int   vd_cnt = 0, dr_cnt = 0, req_rise_cnt = 0, ready_fall_cnt = 0, dbl_cnt = 0;
  logic p_rdy = 1'b1, p_ready = 1'b1, p_req = 1'b0, p_vd = 1'b0, p_dr = 1'b0;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (TX_Rdy && !p_rdy) last_rdy_rise <= cyc;
    if (DMA_Ready && !p_ready) last_ready_rise <= cyc;
    if (!DMA_Ready && p_ready) ready_fall_cnt <= ready_fall_cnt + 1;
    if (DMA_Req && !p_req) begin
      last_req_rise <= cyc;
      req_rise_cnt  <= req_rise_cnt + 1;
    end
    if (Valid_D) vd_cnt <= vd_cnt + 1;
    if (Data_Read) dr_cnt <= dr_cnt + 1;
    if ((Valid_D && p_vd) || (Data_Read && p_dr)) dbl_cnt <= dbl_cnt + 1;
    p_rdy   <= TX_Rdy;
    p_ready <= DMA_Ready;
    p_req   <= DMA_Req;
    p_vd    <= Valid_D;
    p_dr    <= Data_Read;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wp] = b;
    rx_wp = rx_wp + 4'd1;
  endtask

  task automatic pulse_start();
    DMA_Tx_Start = 1'b1;
    @(negedge Clk);
    DMA_Tx_Start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 3000) begin
      @(negedge Clk);
      n++;
      if (DMA_Ready && !DMA_Req && !RX_Valid && TX_Rdy && !DMA_Tx_Start) quiet++;
      else quiet = 0;
    end
    check({tag, "_idle"}, 32'(quiet >= 4), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!DMA_Req && n < 500) begin
      @(negedge Clk);
      n++;
    end
    check({tag, "_req"}, 32'(DMA_Req), 32'd1);
  endtask

  function automatic logic [15:0] wr_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 16'hDEAD;
  endfunction

  function automatic logic [7:0] tx_at(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 8'hEE;
  endfunction

  initial begin
    int wm, txm, vdm, rqm, rfm, drm, rdm, hold_bad, n;
    Rst_n = 1'b0;
    DMA_Tx_Start = 1'b0;
    mem[8'h04] = 8'hA5;
    mem[8'h05] = 8'h5A;
    repeat (3) @(negedge Clk);
    check("rst_ready", 32'(DMA_Ready), 32'd1);
    check("rst_ctl", 32'({Data_Read, Valid_D, DMA_Req, RAM_Cs, RAM_Wen, RAM_Oen}), 32'd0);
    check("rst_addr", 32'(RAM_Addr), 32'd0);
    check("rst_txdata", 32'(TX_Data), 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // 1: reset while stuck in TX_SEND
    tx_block = 1'b1;
    pulse_start();
    repeat (5) @(negedge Clk);
    check("t1_pre_ready", 32'(DMA_Ready), 32'd0);
    check("t1_pre_txdata", 32'(TX_Data), 32'h A5);
    #2 Rst_n = 1'b0;
    #1;
    check("t1_rst_ready", 32'(DMA_Ready), 32'd1);
    check("t1_rst_txdata", 32'(TX_Data), 32'd0);
    check("t1_rst_ctl", 32'({Data_Read, Valid_D, DMA_Req, RAM_Cs, RAM_Wen, RAM_Oen}), 32'd0);
    check("t1_rst_bus", 32'({RAM_Addr, DataOut}), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    tx_block = 1'b0;
    @(negedge Clk);
    rdm = rd_log.size();
    pulse_start();
    wait_idle("t1");
    check("t1_rd_addr", 32'((rd_log.size() > rdm) ? rd_log[rdm] : 8'hEE), 32'h04);

    // 2: three RX bytes then the flag write
    ack_delay = 2;
    wm = wr_log.size(); drm = dr_cnt; rqm = req_rise_cnt;
    push_rx(8'h12); push_rx(8'h34); push_rx(8'h56);
    wait_idle("t2");
    check("t2_wr0", 32'(wr_at(wm)),     32'h0012);
    check("t2_wr1", 32'(wr_at(wm + 1)), 32'h0134);
    check("t2_wr2", 32'(wr_at(wm + 2)), 32'h0256);
    check("t2_flag", 32'(wr_at(wm + 3)), 32'h03FF);
    check("t2_nwr", 32'(wr_log.size() - wm), 32'd4);
    check("t2_pops", 32'(dr_cnt - drm), 32'd3);
    check("t2_req_rises", 32'(req_rise_cnt - rqm), 32'd3);

    // 3: TX job of two bytes
    txm = tx_log.size(); vdm = vd_cnt;
    check("t3_ready_before", 32'(DMA_Ready), 32'd1);
    pulse_start();
    check("t3_ready_fall", 32'(DMA_Ready), 32'd0);
    wait_idle("t3");
    check("t3_byte0", 32'(tx_at(txm)), 32'hA5);
    check("t3_byte1", 32'(tx_at(txm + 1)), 32'h5A);
    check("t3_strobes", 32'(vd_cnt - vdm), 32'd2);
    check("t3_ready_lag", 32'(last_ready_rise - last_rdy_rise), 32'd1);

    // 4: RX and TX start in the same idle cycle
    wm = wr_log.size(); txm = tx_log.size(); rqm = req_rise_cnt;
    push_rx(8'h77);
    pulse_start();
    check("t4_no_req", 32'(DMA_Req), 32'd0);
    wait_idle("t4");
    check("t4_tx_bytes", 32'(tx_log.size() - txm), 32'd2);
    check("t4_wr", 32'(wr_at(wm)), 32'h0077);
    check("t4_req_rises", 32'(req_rise_cnt - rqm), 32'd1);
    check("t4_order", 32'(last_req_rise > last_ready_rise), 32'd1);

    // 5: two start pulses during the last RX byte collapse into one job
    ack_delay = 6;
    wm = wr_log.size(); txm = tx_log.size(); vdm = vd_cnt; rfm = ready_fall_cnt;
    push_rx(8'h88); push_rx(8'h99);
    n = 0;
    while (wr_log.size() <= wm && n < 500) begin
      @(negedge Clk);
      n++;
    end
    check("t5_first_wr", 32'(wr_log.size() - wm), 32'd1);
    wait_req("t5");
    pulse_start();
    @(negedge Clk);
    pulse_start();
    check("t5_ready_held", 32'(DMA_Ready), 32'd1);
    wait_idle("t5");
    check("t5_wr1", 32'(wr_at(wm + 1)), 32'h0299);
    check("t5_flag", 32'(wr_at(wm + 2)), 32'h03FF);
    check("t5_jobs", 32'(ready_fall_cnt - rfm), 32'd1);
    check("t5_strobes", 32'(vd_cnt - vdm), 32'd2);
    check("t5_byte1", 32'(tx_at(txm + 1)), 32'h5A);

    // 6: grant withheld for ~50 cycles
    ack_delay = 50;
    wm = wr_log.size(); drm = dr_cnt;
    push_rx(8'h42);
    wait_req("t6");
    hold_bad = 0;
    repeat (45) begin
      @(negedge Clk);
      if (!DMA_Req || RAM_Cs || Data_Read) hold_bad++;
    end
    check("t6_hold", 32'(hold_bad), 32'd0);
    check("t6_no_pop", 32'(dr_cnt - drm), 32'd0);
    wait_idle("t6");
    check("t6_wr", 32'(wr_at(wm)), 32'h0042);
    check("t6_pop", 32'(dr_cnt - drm), 32'd1);
    check("strobe_width", 32'(dbl_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
DMA engine at the far end of the CPU's DMA handshake (DMA_Req/DMA_Ack/DMA_Tx_Start/DMA_Ready).
- RX path: takes bytes from the serial receiver FIFO, requests the shared RAM bus and writes each byte into a fixed RAM window. After a full command it writes a flag byte.
- TX path: on a CPU Tx_Start pulse, reads a fixed RAM window and feeds the bytes to the serial transmitter, then reports completion via DMA_Ready.

Parameters:
RX_BASE, 8'h00, RAM address of the first received byte
RX_LEN, 3, bytes per received command (>=1)
FLAG_ADDR, 8'h03, RAM address written after RX_LEN bytes
FLAG_VAL, 8'hFF, value written to FLAG_ADDR
TX_BASE, 8'h04, RAM address of the first byte to transmit
TX_LEN, 2, bytes per transmit job (>=1)

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
RX_Data  in  8  head byte of receiver FIFO; stable while RX_Valid=1 and not popped
RX_Valid  in  1  receiver FIFO non-empty
Data_Read  out  1  one-cycle pop strobe to receiver FIFO
TX_Data  out  8  byte to transmitter
Valid_D  out  1  one-cycle start strobe to transmitter
TX_Rdy  in  1  transmitter idle
DMA_Req  out  1  bus request to CPU
DMA_Ack  in  1  bus grant from CPU
DMA_Tx_Start  in  1  one-cycle pulse from CPU: start TX job
DMA_Ready  out  1  1 = no TX job in progress
RAM_Addr  out  8  RAM address (0 when not driving)
RAM_Cs  out  1  RAM chip select
RAM_Wen  out  1  RAM write enable
RAM_Oen  out  1  RAM output enable
DataOut  out  8  RAM write data (0 when not driving)
DataIn  in  8  RAM read data, valid one cycle after Cs&Oen

Behaviour:
- Reset (async, Rst_n=0):
  - State=IDLE; rx_idx=0; tx_idx=0; tx_pend=0; TX_Data=0.
  - All strobes, DMA_Req and RAM controls =0; RAM_Addr=0; DataOut=0; DMA_Ready=1.
  - Reset mid-job abandons the job with no partial flag write.
- Outputs are decoded from state/counter registers only. Exceptions: DataOut=RX_Data in RX_WRITE, and DMA_Ready, which is a register.
- Counters: rx_idx width $clog2(RX_LEN+1), wraps to 0 after the flag write. tx_idx wraps to 0 at job end. Address = base + idx, mod 256.
- States:
  - IDLE:
    - If DMA_Tx_Start or tx_pend is set, go TX_READ: DMA_Ready<=0, tx_pend<=0. TX has priority over RX.
    - Else if RX_Valid, go RX_REQ.
  - RX_REQ: DMA_Req=1. Wait for DMA_Ack=1 (sampled), then go RX_WRITE.
  - RX_WRITE (1 cycle): DMA_Req=1, RAM_Cs=1, RAM_Wen=1, RAM_Addr=RX_BASE+rx_idx, DataOut=RX_Data, Data_Read=1.
    - If rx_idx==RX_LEN-1, go RX_FLAG.
    - Else rx_idx++ and go IDLE.
  - RX_FLAG (1 cycle): DMA_Req=1, RAM_Cs=1, RAM_Wen=1, RAM_Addr=FLAG_ADDR, DataOut=FLAG_VAL. Then rx_idx<=0 and go IDLE.
  - DMA_Req drops the cycle after the last write. The CPU must hold DMA_Ack while DMA_Req=1; DMA_Ack is not re-checked after the grant.
  - TX_READ (1 cycle): RAM_Cs=1, RAM_Oen=1, RAM_Addr=TX_BASE+tx_idx. Go TX_LATCH.
  - TX_LATCH (1 cycle): same RAM drive. Capture DataIn into TX_Data. Go TX_SEND.
  - TX_SEND: wait for TX_Rdy=1, then Valid_D=1 for exactly 1 cycle and go TX_BUSY.
  - TX_BUSY: wait for TX_Rdy=0.
    - If tx_idx==TX_LEN-1, tx_idx<=0 and go TX_DONE.
    - Else tx_idx++ and go TX_READ.
  - TX_DONE: wait for TX_Rdy=1, then DMA_Ready<=1 and go IDLE.
- TX_Data holds its last value between jobs.
- DMA_Tx_Start while not IDLE sets tx_pend, serviced on the next IDLE. Multiple pulses collapse into one job.
- RX_Valid during a TX job is ignored until IDLE. The receiver FIFO buffers.
- RX_Valid falling while in RX_REQ: keep requesting. The receiver contract forbids this case.
- DMA_Ack high while not requesting: ignored.
- Data_Read and Valid_D never assert for more than 1 consecutive cycle.

Test Plan:
1. Reset mid-TX_SEND (Rst_n low 2 cycles) -> all outputs 0 and DMA_Ready=1 asynchronously; the next Tx_Start reads address 0x04 again.
2. Push 0x12, 0x34, 0x56 to RX, CPU grants Ack 2 cycles after each Req:
   - RAM writes [0x00]=0x12, [0x01]=0x34, [0x02]=0x56, then [0x03]=0xFF.
   - 3 Data_Read pulses; DMA_Req low in between bytes.
3. RAM[0x04]=0xA5, [0x05]=0x5A, pulse DMA_Tx_Start, transmitter model drops TX_Rdy for 20 cycles per byte:
   - DMA_Ready falls the next cycle.
   - Valid_D pulses with TX_Data=0xA5, then 0x5A.
   - DMA_Ready rises 1 cycle after the final TX_Rdy rise.
4. RX_Valid and DMA_Tx_Start asserted in the same IDLE cycle -> TX job runs first with no DMA_Req. RX byte then written at 0x00 after DMA_Ready=1.
5. DMA_Tx_Start pulsed twice during an RX write sequence -> exactly one TX job (2 Valid_D pulses) after RX completes.
6. Hold DMA_Ack=0 for 50 cycles with RX_Valid=1 -> DMA_Req stays 1, no RAM_Cs and no Data_Read until Ack arrives.
